// File: rtl/vga_frame_capture_if.sv
// Bus bundle between a VGA-timed source/RAM side (master) and the frame capture block (slave).
interface vga_frame_capture_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 19
);
  logic                  hsync_i;
  logic                  vsync_i;
  logic [DATA_WIDTH-1:0] pixel_i;
  logic                  capture_req_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_address_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  busy_o;
  logic                  frame_done_o;
  logic                  error_o;

  modport master (
    output hsync_i, vsync_i, pixel_i, capture_req_i,
    input  wr_en_o, wr_address_o, wr_data_o, busy_o, frame_done_o, error_o
  );

  modport slave (
    input  hsync_i, vsync_i, pixel_i, capture_req_i,
    output wr_en_o, wr_address_o, wr_data_o, busy_o, frame_done_o, error_o
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Captures one active VGA frame into a linear RAM write port on request,
// flagging short lines and short frames as a sticky timing error.
module vga_frame_capture #(
  parameter int ACTIVE_COLUMNS  = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int H_BACK_PORCH    = 48,
  parameter int V_SKIP_LINES    = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int DATA_WIDTH      = 1,
  parameter int ADDR_WIDTH      = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
  input logic               clk_i,
  input logic               reset_i,
  vga_frame_capture_if.slave bus
);

  localparam int COL_W    = (ACTIVE_COLUMNS > 1) ? $clog2(ACTIVE_COLUMNS) : 1;
  localparam int ROW_W    = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
  localparam int WAIT_MAX = (V_SKIP_LINES > H_BACK_PORCH) ? V_SKIP_LINES : H_BACK_PORCH;
  localparam int WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(ACTIVE_COLUMNS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ACTIVE_ROWS - 1);
  localparam logic [WAIT_W-1:0] SKIP_LAST  = WAIT_W'(V_SKIP_LINES);
  localparam logic [WAIT_W-1:0] PORCH_LAST = WAIT_W'(H_BACK_PORCH - 2);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    VSKIP,
    HPORCH,
    ACTIVE,
    HWAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic                  hs_act, vs_act;
  logic                  hs_q, hs_d, vs_q, vs_d, req_q;
  logic [DATA_WIDTH-1:0] pix_q;
  logic                  hs_assert, hs_deassert, vs_assert, vs_deassert;

  logic [WAIT_W-1:0]     wait_cnt, wait_n;
  logic [COL_W-1:0]      col_cnt, col_n;
  logic [ROW_W-1:0]      row_cnt, row_n;
  logic [ADDR_WIDTH-1:0] addr_cnt, addr_n;

  logic                  wr_en_r, wr_en_n;
  logic [ADDR_WIDTH-1:0] wr_address_r, wr_address_n;
  logic [DATA_WIDTH-1:0] wr_data_r, wr_data_n;
  logic                  busy_r, busy_n;
  logic                  done_r, done_n;
  logic                  error_r, error_n;
  logic                  abort;

  // Syncs are normalised to 1 = active before registering so edge logic is polarity-free.
  // The request goes through the same stage, which keeps a request that lands on the
  // vsync deassert from catching that same edge.
  assign hs_act = bus.hsync_i ^ SYNC_ACTIVE_LOW;
  assign vs_act = bus.vsync_i ^ SYNC_ACTIVE_LOW;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hs_q  <= 1'b0;
      hs_d  <= 1'b0;
      vs_q  <= 1'b0;
      vs_d  <= 1'b0;
      req_q <= 1'b0;
      pix_q <= '0;
    end else begin
      hs_q  <= hs_act;
      hs_d  <= hs_q;
      vs_q  <= vs_act;
      vs_d  <= vs_q;
      req_q <= bus.capture_req_i;
      pix_q <= bus.pixel_i;
    end
  end

  assign hs_assert   = ~hs_d &  hs_q;
  assign hs_deassert =  hs_d & ~hs_q;
  assign vs_assert   = ~vs_d &  vs_q;
  assign vs_deassert =  vs_d & ~vs_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      addr_cnt     <= '0;
      wr_en_r      <= 1'b0;
      wr_address_r <= '0;
      wr_data_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_n;
      col_cnt      <= col_n;
      row_cnt      <= row_n;
      addr_cnt     <= addr_n;
      wr_en_r      <= wr_en_n;
      wr_address_r <= wr_address_n;
      wr_data_r    <= wr_data_n;
      busy_r       <= busy_n;
      done_r       <= done_n;
      error_r      <= error_n;
    end
  end

  // The write for pixel column c is decided while pix_q holds it, so wr_* land two
  // cycles after the raw sample; HPORCH therefore lasts one clock less than the porch.
  always_comb begin
    state_n      = state;
    wait_n       = wait_cnt;
    col_n        = col_cnt;
    row_n        = row_cnt;
    addr_n       = addr_cnt;
    wr_en_n      = 1'b0;
    wr_address_n = wr_address_r;
    wr_data_n    = wr_data_r;
    busy_n       = busy_r;
    done_n       = 1'b0;
    error_n      = error_r;
    abort        = 1'b0;

    case (state)
      IDLE: begin
        if (req_q) begin
          state_n = ARMED;
          busy_n  = 1'b1;
          error_n = 1'b0;
        end
      end
      ARMED: begin
        if (vs_deassert) begin
          state_n = VSKIP;
          wait_n  = '0;
          row_n   = '0;
          addr_n  = '0;
        end
      end
      VSKIP: begin
        if (hs_deassert) begin
          if (wait_cnt == SKIP_LAST) begin
            state_n = HPORCH;
            wait_n  = '0;
            row_n   = '0;
          end else begin
            wait_n = wait_cnt + WAIT_W'(1);
          end
        end
      end
      HPORCH: begin
        if (wait_cnt == PORCH_LAST) begin
          state_n = ACTIVE;
          col_n   = '0;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      ACTIVE: begin
        if (hs_assert) begin
          abort = 1'b1;
        end else begin
          wr_en_n      = 1'b1;
          wr_address_n = addr_cnt;
          wr_data_n    = pix_q;
          addr_n       = addr_cnt + ADDR_WIDTH'(1);
          if (col_cnt == LAST_COL) begin
            col_n   = '0;
            state_n = (row_cnt == LAST_ROW) ? DONE : HWAIT;
          end else begin
            col_n = col_cnt + COL_W'(1);
          end
        end
      end
      HWAIT: begin
        if (hs_deassert) begin
          state_n = HPORCH;
          wait_n  = '0;
          row_n   = row_cnt + ROW_W'(1);
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (vs_assert && (state == HPORCH || state == ACTIVE || state == HWAIT)) begin
      abort = 1'b1;
    end

    // A timing error cancels the pending write and drops straight back to IDLE.
    if (abort) begin
      state_n      = IDLE;
      wr_en_n      = 1'b0;
      wr_address_n = wr_address_r;
      wr_data_n    = wr_data_r;
      addr_n       = addr_cnt;
      busy_n       = 1'b0;
      done_n       = 1'b0;
      error_n      = 1'b1;
    end
  end

  assign bus.wr_en_o      = wr_en_r;
  assign bus.wr_address_o = wr_address_r;
  assign bus.wr_data_o    = wr_data_r;
  assign bus.busy_o       = busy_r;
  assign bus.frame_done_o = done_r;
  assign bus.error_o      = error_r;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a tiny 8x4 raster with a task-based VGA timing generator.
module tb_vga_frame_capture;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int AW   = 5;
  localparam int LOG  = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int vectors     = 0;
  int miscompares = 0;

  int   wr_cnt   = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   addr_log [LOG];
  logic data_log [LOG];
  int   cyc_log  [LOG];

  int wb, db, tf, tl;

  vga_frame_capture_if #(.DATA_WIDTH(1), .ADDR_WIDTH(AW)) vif ();

  vga_frame_capture #(
    .ACTIVE_COLUMNS (COLS),
    .ACTIVE_ROWS    (ROWS),
    .H_BACK_PORCH   (2),
    .V_SKIP_LINES   (1),
    .SYNC_ACTIVE_LOW(1'b1),
    .DATA_WIDTH     (1),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .bus    (vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done logger, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (vif.wr_en_o === 1'b1) begin
      if (wr_cnt < LOG) begin
        addr_log[wr_cnt] = int'(vif.wr_address_o);
        data_log[wr_cnt] = vif.wr_data_o;
        cyc_log[wr_cnt]  = cyc;
      end
      wr_cnt++;
    end
    if (vif.frame_done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic par(input int a);
    logic [4:0] v;
    v = a[4:0];
    return ^v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit hs, input bit vs, input logic px, input bit req);
    vif.hsync_i       = ~hs;
    vif.vsync_i       = ~vs;
    vif.pixel_i       = px;
    vif.capture_req_i = req;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b1, 0);
  endtask

  task automatic request();
    step(0, 0, 1'b1, 1);
    idle(2);
  endtask

  // One line: 2 sync clocks, 2 porch clocks, n_act pixels, 2 front-porch clocks when full.
  task automatic send_line(input bit act, input int row, input int n_act, input bit req,
                           input int rst_col, output int t);
    step(1, 0, 1'b1, req);
    step(1, 0, 1'b1, 0);
    t = cyc;
    step(0, 0, 1'b1, 0);
    step(0, 0, 1'b1, 0);
    if (act) begin
      for (int c = 0; c < n_act; c++) begin
        if (c == rst_col + 3) rst_n = 1'b1;
        if (c == rst_col) begin
          rst_n = 1'b0;
          #1;
          check("rst_wr_en", vif.wr_en_o, 0);
          check("rst_wr_address", vif.wr_address_o, 0);
          check("rst_wr_data", vif.wr_data_o, 0);
          check("rst_busy", vif.busy_o, 0);
          check("rst_frame_done", vif.frame_done_o, 0);
          check("rst_error", vif.error_o, 0);
        end
        step(0, 0, par(row * COLS + c), 0);
      end
      if (n_act == COLS) begin
        step(0, 0, 1'b1, 0);
        step(0, 0, 1'b1, 0);
      end
    end else begin
      for (int c = 0; c < COLS + 2; c++) step(0, 0, 1'b1, 0);
    end
  endtask

  task automatic send_frame(input int n_rows, input int short_row, input int rst_row,
                            input bit req_at_vs, input int req_row,
                            output int t_first, output int t_last);
    int t;
    t_first = 0;
    t_last  = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 1'b1, 0);
    step(0, 0, 1'b1, req_at_vs);
    send_line(0, 0, COLS, 0, -1, t);
    for (int r = 0; r < n_rows; r++) begin
      send_line(1, r, (r == short_row) ? 5 : COLS, (r == req_row), (r == rst_row) ? 2 : -1, t);
      if (r == 0) t_first = t;
      t_last = t;
    end
  endtask

  task automatic check_clean(input string tag, input int b, input int d, input int t0, input int t3);
    check({tag, "_write_count"}, wr_cnt - b, COLS * ROWS);
    for (int i = 0; i < COLS * ROWS; i++) begin
      check({tag, "_addr"}, addr_log[b + i], i);
      check({tag, "_data"}, data_log[b + i], par(i));
    end
    check({tag, "_first_write_cycle"}, cyc_log[b], t0 + 4);
    check({tag, "_last_write_cycle"}, cyc_log[b + COLS * ROWS - 1], t3 + 11);
    check({tag, "_done_count"}, done_cnt - d, 1);
    check({tag, "_done_cycle"}, done_cyc, t3 + 12);
    check({tag, "_busy_after"}, vif.busy_o, 0);
    check({tag, "_error_after"}, vif.error_o, 0);
  endtask

  initial begin
    vif.hsync_i       = 1'b1;
    vif.vsync_i       = 1'b1;
    vif.pixel_i       = 1'b0;
    vif.capture_req_i = 1'b0;
    rst_n             = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", vif.wr_en_o, 0);
    check("reset_wr_address", vif.wr_address_o, 0);
    check("reset_wr_data", vif.wr_data_o, 0);
    check("reset_busy", vif.busy_o, 0);
    check("reset_frame_done", vif.frame_done_o, 0);
    check("reset_error", vif.error_o, 0);
    rst_n = 1'b1;
    idle(3);

    // Clean capture with latency and contents.
    request();
    check("req_busy", vif.busy_o, 1);
    wb = wr_cnt; db = done_cnt;
    send_frame(ROWS, -1, -1, 0, -1, tf, tl);
    idle(4);
    check_clean("clean", wb, db, tf, tl);

    // Row 1 cut to 5 pixels.
    request();
    wb = wr_cnt; db = done_cnt;
    send_frame(ROWS, 1, -1, 0, -1, tf, tl);
    idle(2);
    check("short_line_writes", wr_cnt - wb, COLS + 5);
    check("short_line_last_addr", addr_log[wb + COLS + 4], COLS + 4);
    check("short_line_done", done_cnt - db, 0);
    check("short_line_error", vif.error_o, 1);
    check("short_line_busy", vif.busy_o, 0);

    // Next request clears the error and captures a good frame.
    request();
    check("recover_error_cleared", vif.error_o, 0);
    check("recover_busy", vif.busy_o, 1);
    wb = wr_cnt; db = done_cnt;
    send_frame(ROWS, -1, -1, 0, -1, tf, tl);
    idle(4);
    check_clean("recover", wb, db, tf, tl);

    // vsync returns after row 2.
    request();
    wb = wr_cnt; db = done_cnt;
    send_frame(3, -1, -1, 0, -1, tf, tl);
    for (int i = 0; i < 4; i++) step(0, 1, 1'b1, 0);
    check("short_frame_writes", wr_cnt - wb, 24);
    check("short_frame_last_addr", addr_log[wb + 23], 23);
    check("short_frame_done", done_cnt - db, 0);
    check("short_frame_error", vif.error_o, 1);
    check("short_frame_busy", vif.busy_o, 0);

    // Request on the vsync deassert plus extra requests while busy.
    wb = wr_cnt; db = done_cnt;
    send_frame(ROWS, -1, -1, 1, 1, tf, tl);
    check("armed_frame_no_writes", wr_cnt - wb, 0);
    check("armed_busy", vif.busy_o, 1);
    send_frame(ROWS, -1, -1, 0, 2, tf, tl);
    idle(4);
    check_clean("next_frame", wb, db, tf, tl);
    wb = wr_cnt; db = done_cnt;
    send_frame(ROWS, -1, -1, 0, -1, tf, tl);
    idle(4);
    check("single_capture_writes", wr_cnt - wb, 0);
    check("single_capture_done", done_cnt - db, 0);

    // Reset in the middle of row 1, then a full clean capture.
    request();
    db = done_cnt;
    send_frame(ROWS, -1, 1, 0, -1, tf, tl);
    idle(2);
    check("post_reset_busy", vif.busy_o, 0);
    check("post_reset_error", vif.error_o, 0);
    check("post_reset_done", done_cnt - db, 0);
    request();
    wb = wr_cnt; db = done_cnt;
    send_frame(ROWS, -1, -1, 0, -1, tf, tl);
    idle(4);
    check_clean("after_reset", wb, db, tf, tl);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
